ifm_window_buf: RTL

- Parametrised KxK input-feature-map window buffer. It feeds the KxK PE array and sits between the IFM fetch unit and the PE array.
- CONV mode walks a tile of window positions in serpentine order. Each step after the first reuses K*(K-1) pixels and fetches one new K-pixel column or row.
- POOL mode reloads every window from scratch in raster order.
- Both sides use valid/ready handshakes, with start/done/abort control.

---
 rtl/ifm_window_buf_pkg.sv | 28 ++
 rtl/ifm_window_buf_scan_ctr.sv | 50 +++++
 rtl/ifm_window_buf.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_window_buf_pkg.sv
// Shared types and constants for the IFM window buffer.
package ifm_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    SHIFT,
    DONE
  } state_e;

  // The encoding is visible on in_need, so the values are fixed.
  typedef enum logic [1:0] {
    NEED_LOAD  = 2'b00,
    NEED_RIGHT = 2'b01,
    NEED_LEFT  = 2'b10,
    NEED_DOWN  = 2'b11
  } need_e;

  localparam logic [1:0] CONVOLUTION = 2'b01;
  localparam logic [1:0] POOLING     = 2'b10;

  // Only POOLING selects raster reload; every other code is treated as convolution.
  function automatic logic is_pool(input logic [1:0] lt);
    return lt == POOLING;
  endfunction

endpackage

// File: rtl/ifm_window_buf_scan_ctr.sv
// Window-position counters for one tile: serpentine walk in convolution,
// raster walk in pooling. Reports where the current position sits in the tile.
module ifm_scan_ctr
  import ifm_buf_pkg::*;
#(
  parameter int POS_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  input  logic             pool,
  input  logic [POS_W-1:0] cfg_cols,
  input  logic [POS_W-1:0] cfg_rows,
  output logic             row_end,
  output logic             tile_end,
  output logic             dir_left
);

  logic [POS_W-1:0] pos_x;
  logic [POS_W-1:0] pos_y;

  // Odd rows travel leftwards in convolution; pooling always restarts at column 0.
  assign dir_left = pos_y[0] & ~pool;
  assign row_end  = dir_left ? (pos_x == '0) : (pos_x == cfg_cols - POS_W'(1));
  assign tile_end = row_end & (pos_y == cfg_rows - POS_W'(1));

  // Advance one window position per step; clear returns to the tile origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (clear) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (step) begin
      if (row_end) begin
        pos_y <= pos_y + POS_W'(1);
        if (pool) begin
          pos_x <= '0;
        end
      end else if (dir_left) begin
        pos_x <= pos_x - POS_W'(1);
      end else begin
        pos_x <= pos_x + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/ifm_window_buf.sv
// KxK input-feature-map window buffer between the IFM fetch unit and the PE array.
// Convolution reuses K*(K-1) pixels per step; pooling reloads every window.
module ifm_window_buf
  import ifm_buf_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int K       = 3,
  parameter int MAX_POS = 64,
  parameter int POS_W   = $clog2(MAX_POS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            layer_type,
  input  logic                  start,
  input  logic                  abort,
  input  logic [POS_W-1:0]      cfg_cols,
  input  logic [POS_W-1:0]      cfg_rows,
  input  logic [K*DATA_W-1:0]   in_vec,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            in_need,
  output logic [K*K*DATA_W-1:0] win,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int LROW_W = $clog2(K);

  state_e                   state_q, state_d;
  need_e                    shift_need_q, need_d;
  logic [1:0]               layer_q;
  logic [POS_W-1:0]         cols_q;
  logic [POS_W-1:0]         rows_q;
  logic [LROW_W-1:0]        load_row_q;
  logic                     cfg_load;
  logic                     ctr_clear;
  logic                     ctr_step;
  logic                     row_end;
  logic                     tile_end;
  logic                     dir_left;
  logic                     pool_mode;
  logic                     in_beat;
  logic                     handoff;
  logic signed [DATA_W-1:0] in_px [K];
  logic signed [DATA_W-1:0] win_q [K*K];
  logic signed [DATA_W-1:0] win_d [K*K];

  assign pool_mode = is_pool(layer_q);

  // Outputs decode the registered state only, so no input reaches them combinationally.
  assign in_ready  = (state_q == LOAD) || (state_q == SHIFT);
  assign win_valid = (state_q == EMIT);
  assign busy      = (state_q == LOAD) || (state_q == EMIT) || (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign in_need   = (state_q == SHIFT) ? shift_need_q : NEED_LOAD;

  assign in_beat = in_valid & in_ready;
  assign handoff = win_valid & win_ready;

  ifm_scan_ctr #(
    .POS_W(POS_W)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (ctr_clear),
    .step     (ctr_step),
    .pool     (pool_mode),
    .cfg_cols (cols_q),
    .cfg_rows (rows_q),
    .row_end  (row_end),
    .tile_end (tile_end),
    .dir_left (dir_left)
  );

  // Split the incoming vector into its K signed pixels.
  always_comb begin
    for (int c = 0; c < K; c++) begin
      in_px[c] = $signed(in_vec[c*DATA_W +: DATA_W]);
    end
  end

  // Flatten the window array onto the output bus, element r*K+c per lane.
  always_comb begin
    for (int i = 0; i < K*K; i++) begin
      win[i*DATA_W +: DATA_W] = win_q[i];
    end
  end

  // Next-state logic; abort outranks every transition except in IDLE.
  always_comb begin
    state_d   = state_q;
    need_d    = shift_need_q;
    cfg_load  = 1'b0;
    ctr_clear = 1'b0;
    ctr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cfg_load  = 1'b1;
          ctr_clear = 1'b1;
          state_d   = (cfg_cols == '0 || cfg_rows == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (in_beat && load_row_q == LROW_W'(K-1)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (handoff) begin
          if (tile_end) begin
            state_d = DONE;
          end else begin
            ctr_step = 1'b1;
            if (pool_mode) begin
              state_d = LOAD;
            end else begin
              state_d = SHIFT;
              if (row_end) begin
                need_d = NEED_DOWN;
              end else if (dir_left) begin
                need_d = NEED_LEFT;
              end else begin
                need_d = NEED_RIGHT;
              end
            end
          end
        end
      end
      SHIFT: begin
        if (in_beat) begin
          state_d = EMIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      ctr_step = 1'b0;
    end
  end

  // Control registers: FSM state, latched tile configuration and load-row index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_need_q <= NEED_LOAD;
      layer_q      <= CONVOLUTION;
      cols_q       <= '0;
      rows_q       <= '0;
      load_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_need_q <= need_d;
      if (cfg_load) begin
        layer_q    <= layer_type;
        cols_q     <= cfg_cols;
        rows_q     <= cfg_rows;
        load_row_q <= '0;
      end else if (state_q == LOAD && in_beat && !abort) begin
        load_row_q <= (load_row_q == LROW_W'(K-1)) ? '0 : load_row_q + LROW_W'(1);
      end
    end
  end

  // Window update: fill one row in LOAD, or slide by one column/row in SHIFT.
  always_comb begin
    win_d = win_q;
    if (in_beat && !abort) begin
      if (state_q == LOAD) begin
        for (int r = 0; r < K; r++) begin
          if (LROW_W'(r) == load_row_q) begin
            for (int c = 0; c < K; c++) begin
              win_d[r*K+c] = in_px[c];
            end
          end
        end
      end else begin
        case (shift_need_q)
          NEED_RIGHT: begin
            for (int r = 0; r < K; r++) begin
              for (int c = 0; c < K-1; c++) begin
                win_d[r*K+c] = win_q[r*K+c+1];
              end
              win_d[r*K+K-1] = in_px[r];
            end
          end
          NEED_LEFT: begin
            for (int r = 0; r < K; r++) begin
              for (int c = 1; c < K; c++) begin
                win_d[r*K+c] = win_q[r*K+c-1];
              end
              win_d[r*K] = in_px[r];
            end
          end
          NEED_DOWN: begin
            for (int c = 0; c < K; c++) begin
              for (int r = 0; r < K-1; r++) begin
                win_d[r*K+c] = win_q[(r+1)*K+c];
              end
              win_d[(K-1)*K+c] = in_px[c];
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Window storage; held across handoff stalls and across abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K*K; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      win_q <= win_d;
    end
  end

endmodule
